// File: rtl/al4s3b_wb_initiator_if.sv
// rtl/al4s3b_wb_initiator_if.sv - command, response and Wishbone master signal bundle
interface al4s3b_wb_initiator_if #(
  parameter int ADDRWIDTH = 17,
  parameter int DATAWIDTH = 32
);
  logic                 CMD_VALID_i;
  logic                 CMD_READY_o;
  logic [ADDRWIDTH-1:0] CMD_ADR_i;
  logic                 CMD_WE_i;
  logic [3:0]           CMD_BYTE_STB_i;
  logic [DATAWIDTH-1:0] CMD_WR_DAT_i;
  logic                 RSP_VALID_o;
  logic                 RSP_READY_i;
  logic [DATAWIDTH-1:0] RSP_RD_DAT_o;
  logic                 RSP_ERR_o;
  logic [ADDRWIDTH-1:0] WBm_ADR_o;
  logic                 WBm_CYC_o;
  logic                 WBm_STB_o;
  logic                 WBm_WE_o;
  logic                 WBm_RD_o;
  logic [3:0]           WBm_BYTE_STB_o;
  logic [DATAWIDTH-1:0] WBm_WR_DAT_o;
  logic [DATAWIDTH-1:0] WBm_RD_DAT_i;
  logic                 WBm_ACK_i;

  modport master (
    input  CMD_VALID_i, CMD_ADR_i, CMD_WE_i, CMD_BYTE_STB_i, CMD_WR_DAT_i,
    input  RSP_READY_i, WBm_RD_DAT_i, WBm_ACK_i,
    output CMD_READY_o, RSP_VALID_o, RSP_RD_DAT_o, RSP_ERR_o,
    output WBm_ADR_o, WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_RD_o,
    output WBm_BYTE_STB_o, WBm_WR_DAT_o
  );

  modport slave (
    output CMD_VALID_i, CMD_ADR_i, CMD_WE_i, CMD_BYTE_STB_i, CMD_WR_DAT_i,
    output RSP_READY_i, WBm_RD_DAT_i, WBm_ACK_i,
    input  CMD_READY_o, RSP_VALID_o, RSP_RD_DAT_o, RSP_ERR_o,
    input  WBm_ADR_o, WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_RD_o,
    input  WBm_BYTE_STB_o, WBm_WR_DAT_o
  );
endinterface

// File: rtl/al4s3b_wb_initiator.sv
// rtl/al4s3b_wb_initiator.sv - single-outstanding Wishbone classic initiator with ACK timeout
module al4s3b_wb_initiator #(
  parameter int                      ADDRWIDTH          = 17,
  parameter int                      DATAWIDTH          = 32,
  parameter int                      TO_CNT_WIDTH       = 8,
  parameter logic [TO_CNT_WIDTH-1:0] ACK_TIMEOUT        = 8'd200,
  parameter logic [DATAWIDTH-1:0]    TIMEOUT_READ_VALUE = 32'hBAD_FAB_AC
) (
  input  logic                   WB_CLK,
  input  logic                   WB_RST_n,
  al4s3b_wb_initiator_if.master  bus
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t                  state_q, state_d;
  logic [TO_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDRWIDTH-1:0]    adr_d;
  logic                    we_d;
  logic [3:0]              bs_d;
  logic [DATAWIDTH-1:0]    wdat_d;
  logic [DATAWIDTH-1:0]    rdat_d;
  logic                    err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = bus.WBm_ADR_o;
    we_d    = bus.WBm_WE_o;
    bs_d    = bus.WBm_BYTE_STB_o;
    wdat_d  = bus.WBm_WR_DAT_o;
    rdat_d  = bus.RSP_RD_DAT_o;
    err_d   = bus.RSP_ERR_o;
    case (state_q)
      IDLE: begin
        // CMD_READY_o is low in the first cycle after reset, so gate on it
        if (bus.CMD_VALID_i && bus.CMD_READY_o) begin
          adr_d   = bus.CMD_ADR_i;
          we_d    = bus.CMD_WE_i;
          bs_d    = bus.CMD_BYTE_STB_i;
          wdat_d  = bus.CMD_WR_DAT_i;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        if (bus.WBm_ACK_i) begin
          rdat_d  = bus.WBm_WE_o ? '0 : bus.WBm_RD_DAT_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == ACK_TIMEOUT - TO_CNT_WIDTH'(1)) begin
          rdat_d  = TIMEOUT_READ_VALUE;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + TO_CNT_WIDTH'(1);
        end
      end
      RESP: begin
        if (bus.RSP_READY_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Every output is derived from the next state so all of them come straight from flops
  always_ff @(posedge WB_CLK) begin
    if (!WB_RST_n) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      bus.CMD_READY_o    <= 1'b0;
      bus.RSP_VALID_o    <= 1'b0;
      bus.RSP_RD_DAT_o   <= '0;
      bus.RSP_ERR_o      <= 1'b0;
      bus.WBm_ADR_o      <= '0;
      bus.WBm_CYC_o      <= 1'b0;
      bus.WBm_STB_o      <= 1'b0;
      bus.WBm_WE_o       <= 1'b0;
      bus.WBm_RD_o       <= 1'b0;
      bus.WBm_BYTE_STB_o <= '0;
      bus.WBm_WR_DAT_o   <= '0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      bus.CMD_READY_o    <= (state_d == IDLE);
      bus.RSP_VALID_o    <= (state_d == RESP);
      bus.RSP_RD_DAT_o   <= rdat_d;
      bus.RSP_ERR_o      <= err_d;
      bus.WBm_ADR_o      <= adr_d;
      bus.WBm_CYC_o      <= (state_d == BUS);
      bus.WBm_STB_o      <= (state_d == BUS);
      bus.WBm_WE_o       <= we_d;
      bus.WBm_RD_o       <= (state_d == BUS) && !we_d;
      bus.WBm_BYTE_STB_o <= bs_d;
      bus.WBm_WR_DAT_o   <= wdat_d;
    end
  end

endmodule

// File: tb/tb_al4s3b_wb_initiator.sv
// tb/tb_al4s3b_wb_initiator.sv - randomized self-checking bench for al4s3b_wb_initiator
module tb_al4s3b_wb_initiator;

  localparam int          TMO     = 200;
  localparam logic [31:0] TMO_VAL = 32'hBADFABAC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  al4s3b_wb_initiator_if bus ();

  al4s3b_wb_initiator dut (
    .WB_CLK   (clk),
    .WB_RST_n (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.CMD_VALID_i    = 1'b0;
    bus.CMD_ADR_i      = '0;
    bus.CMD_WE_i       = 1'b0;
    bus.CMD_BYTE_STB_i = '0;
    bus.CMD_WR_DAT_i   = '0;
    bus.RSP_READY_i    = 1'b0;
    bus.WBm_RD_DAT_i   = '0;
    bus.WBm_ACK_i      = 1'b0;
  endtask

  // One transaction; n_ack = number of bus cycles until the responder ACKs (0 = never)
  task automatic run_txn(input bit we, input logic [16:0] adr, input logic [3:0] bs,
                         input logic [31:0] wd, input int n_ack, input logic [31:0] rd,
                         input int hold);
    int          eff, cyc_n, rd_n;
    bit          exp_err, bad, hold_bad;
    logic [31:0] exp_dat;
    exp_err = !(n_ack >= 1 && n_ack <= TMO);
    eff     = exp_err ? TMO : n_ack;
    exp_dat = exp_err ? TMO_VAL : (we ? 32'h0 : rd);

    @(negedge clk);
    chk("cmd_ready_idle", bus.CMD_READY_o, 1);
    bus.CMD_VALID_i    = 1'b1;
    bus.CMD_ADR_i      = adr;
    bus.CMD_WE_i       = we;
    bus.CMD_BYTE_STB_i = bs;
    bus.CMD_WR_DAT_i   = wd;
    bus.WBm_ACK_i      = 1'b0;
    @(negedge clk);
    bus.CMD_VALID_i  = 1'b0;
    bus.CMD_WR_DAT_i = $urandom;
    cyc_n = 0; rd_n = 0; bad = 0;
    while (bus.WBm_CYC_o && cyc_n < 300) begin
      cyc_n++;
      if (bus.WBm_RD_o) rd_n++;
      if (bus.WBm_STB_o !== 1'b1 || bus.WBm_ADR_o !== adr || bus.WBm_WE_o !== we ||
          bus.WBm_BYTE_STB_o !== bs || bus.WBm_WR_DAT_o !== wd || bus.CMD_READY_o !== 1'b0 ||
          bus.RSP_VALID_o !== 1'b0)
        bad = 1;
      bus.WBm_ACK_i    = (cyc_n == n_ack);
      bus.WBm_RD_DAT_i = bus.WBm_ACK_i ? rd : $urandom;
      @(negedge clk);
    end
    bus.WBm_ACK_i = 1'b0;
    chk("cyc_cycles", cyc_n, eff);
    chk("rd_cycles", rd_n, we ? 0 : eff);
    chk("bus_stable", bad, 0);
    chk("stb_low", bus.WBm_STB_o, 0);
    chk("rsp_valid", bus.RSP_VALID_o, 1);
    chk("rsp_err", bus.RSP_ERR_o, exp_err);
    chk("rsp_dat", bus.RSP_RD_DAT_o, exp_dat);
    chk("cmd_ready_resp", bus.CMD_READY_o, 0);

    hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      bus.CMD_VALID_i    = 1'b1;
      bus.CMD_ADR_i      = 17'h00A5C;
      bus.CMD_WE_i       = 1'b1;
      bus.CMD_BYTE_STB_i = 4'h3;
      bus.CMD_WR_DAT_i   = 32'hCAFE0001;
      bus.WBm_ACK_i      = $urandom_range(0, 1);
      @(negedge clk);
      if (bus.RSP_VALID_o !== 1'b1 || bus.RSP_ERR_o !== exp_err || bus.RSP_RD_DAT_o !== exp_dat ||
          bus.CMD_READY_o !== 1'b0 || bus.WBm_CYC_o !== 1'b0)
        hold_bad = 1;
    end
    if (hold > 0) chk("rsp_hold_stable", hold_bad, 0);
    bus.WBm_ACK_i   = 1'b0;
    bus.RSP_READY_i = 1'b1;
    @(negedge clk);
    bus.RSP_READY_i = 1'b0;
    chk("rsp_valid_drop", bus.RSP_VALID_o, 0);
    chk("cmd_ready_back", bus.CMD_READY_o, 1);
    chk("cyc_gap", bus.WBm_CYC_o, 0);
    if (hold > 0) begin
      // command still pending from the hold phase is taken at the very next edge
      @(negedge clk);
      bus.CMD_VALID_i = 1'b0;
      chk("b2b_cyc", bus.WBm_CYC_o, 1);
      chk("b2b_adr", bus.WBm_ADR_o, 17'h00A5C);
      chk("b2b_wdat", bus.WBm_WR_DAT_o, 32'hCAFE0001);
      bus.WBm_ACK_i = 1'b1;
      @(negedge clk);
      bus.WBm_ACK_i = 1'b0;
      chk("b2b_rsp", {bus.RSP_VALID_o, bus.RSP_ERR_o, bus.RSP_RD_DAT_o}, {2'b10, 32'h0});
      bus.RSP_READY_i = 1'b1;
      @(negedge clk);
      bus.RSP_READY_i = 1'b0;
    end
  endtask

  task automatic reset_mid_bus();
    @(negedge clk);
    bus.CMD_VALID_i    = 1'b1;
    bus.CMD_ADR_i      = 17'h0ABCD;
    bus.CMD_WE_i       = 1'b1;
    bus.CMD_BYTE_STB_i = 4'hF;
    bus.CMD_WR_DAT_i   = 32'h55AA55AA;
    @(negedge clk);
    bus.CMD_VALID_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_cyc", bus.WBm_CYC_o, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ctl", {bus.WBm_CYC_o, bus.WBm_STB_o, bus.WBm_WE_o, bus.WBm_RD_o,
                    bus.RSP_VALID_o, bus.RSP_ERR_o, bus.CMD_READY_o}, 0);
    chk("rst_dat", {bus.WBm_ADR_o, bus.WBm_BYTE_STB_o}, 0);
    chk("rst_wdat", {bus.WBm_WR_DAT_o, bus.RSP_RD_DAT_o}, 0);
    bus.WBm_ACK_i    = 1'b1;
    bus.WBm_RD_DAT_i = 32'h12121212;
    @(negedge clk);
    chk("post_rst_ready", bus.CMD_READY_o, 1);
    chk("late_ack_cyc", bus.WBm_CYC_o, 0);
    chk("late_ack_rsp", bus.RSP_VALID_o, 0);
    @(negedge clk);
    bus.WBm_ACK_i = 1'b0;
    chk("late_ack_rsp2", bus.RSP_VALID_o, 0);
  endtask

  initial begin
    int n;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("reset_ready", bus.CMD_READY_o, 0);
    chk("reset_cyc", {bus.WBm_CYC_o, bus.WBm_STB_o, bus.RSP_VALID_o, bus.RSP_ERR_o}, 0);
    chk("reset_dat", bus.RSP_RD_DAT_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(1'b1, 17'h04000, 4'hF, 32'h12345678, 1, 32'h0, 0);
    run_txn(1'b0, 17'h051FC, 4'hF, 32'h0, 3, 32'h00010000, 0);
    run_txn(1'b0, 17'h06000, 4'hF, 32'h0, 0, 32'h0, 0);
    run_txn(1'b0, 17'h06004, 4'hF, 32'h0, TMO, 32'h600DF00D, 0);
    run_txn(1'b1, 17'h06008, 4'hF, 32'hDEADBEEF, 0, 32'h0, 0);
    run_txn(1'b0, 17'h00003, 4'h0, 32'h0, 2, 32'h87654321, 10);
    reset_mid_bus();

    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 9))
        0:       n = 0;
        1:       n = TMO;
        default: n = $urandom_range(1, 8);
      endcase
      run_txn($urandom_range(0, 1), 17'($urandom), 4'($urandom), $urandom, n, $urandom,
              $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
